bitwise_issue_arbiter: RTL and testbench

Shares one combinational `bitwise` unit between two issue ports. It round-robin arbitrates between the ports and registers the winning instruction into an execute stage. On leaving that stage it captures the unit's result, and it holds the architectural carry flag that feeds `i_carry`. It sits between the decode/issue logic and the writeback bus.

---
 rtl/types.sv | 36 +++
 rtl/bitwise.sv | 57 +++++
 rtl/bitwise_issue_arbiter.sv | 104 ++++++++++
 tb/tb_bitwise_issue_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/types.sv
// rtl/types.sv - shared instruction and data types for the bitwise execution path
package types;

    typedef logic [63:0] long_t;

    typedef enum logic [3:0] {
        NOP    = 4'd0,
        AND    = 4'd1,
        OR     = 4'd2,
        XOR    = 4'd3,
        NOT    = 4'd4,
        ROLR   = 4'd5,
        ROLL   = 4'd6,
        SHIFTR = 4'd7,
        SHIFTL = 4'd8,
        ADD    = 4'd9
    } opcode_t;

    typedef enum logic [1:0] {
        W8  = 2'd0,
        W16 = 2'd1,
        W32 = 2'd2,
        W64 = 2'd3
    } width_t;

    localparam int USE_CARRY_BIT = 0;

    typedef struct packed {
        opcode_t     opcode;
        width_t      width;
        logic [3:0]  flags;
        long_t       arg0;
        long_t       arg1;
    } instruction_t;

endpackage

// File: rtl/bitwise.sv
// rtl/bitwise.sv - combinational logic/shift/rotate unit with optional carry-out
module bitwise
    import types::*;
(
    input  instruction_t i_instr,
    input  logic         i_carry,
    output long_t        result,
    output logic         o_carry
);

    long_t      mask;
    long_t      v;
    long_t      b;
    logic [6:0] w;
    logic [5:0] n;
    logic       use_c;

    always_comb begin
        case (i_instr.width)
            W8:      begin w = 7'd8;  mask = 64'h0000_0000_0000_00FF; end
            W16:     begin w = 7'd16; mask = 64'h0000_0000_0000_FFFF; end
            W32:     begin w = 7'd32; mask = 64'h0000_0000_FFFF_FFFF; end
            default: begin w = 7'd64; mask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
        v      = i_instr.arg0 & mask;
        b      = i_instr.arg1 & mask;
        // shift/rotate amount wraps modulo the operand width
        n      = i_instr.arg1[5:0] & 6'(w - 7'd1);
        use_c  = i_instr.flags[USE_CARRY_BIT];
        result = '0;
        o_carry = 1'b0;
        case (i_instr.opcode)
            AND: result = v & b;
            OR:  result = v | b;
            XOR: result = v ^ b;
            NOT: result = ~v & mask;
            ROLL: begin
                result  = ((v << n) | (v >> (w - {1'b0, n}))) & mask;
                o_carry = use_c & ((n == 6'd0) ? i_carry : result[0]);
            end
            ROLR: begin
                result  = ((v >> n) | (v << (w - {1'b0, n}))) & mask;
                o_carry = use_c & ((n == 6'd0) ? i_carry : result[6'(w - 7'd1)]);
            end
            SHIFTL: begin
                result  = (v << n) & mask;
                o_carry = use_c & ((n == 6'd0) ? i_carry : v[6'(w - {1'b0, n})]);
            end
            SHIFTR: begin
                result  = v >> n;
                o_carry = use_c & ((n == 6'd0) ? i_carry : v[n - 6'd1]);
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_issue_arbiter.sv
// rtl/bitwise_issue_arbiter.sv - two-port round-robin issue into a shared bitwise unit
module bitwise_issue_arbiter
    import types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  instruction_t req0_instr,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  instruction_t req1_instr,
    output logic         req1_ready,
    output logic         res_valid,
    input  logic         res_ready,
    output long_t        res_data,
    output logic         res_carry,
    output logic         res_tag,
    output logic         carry_flag,
    input  logic         carry_wr_en,
    input  logic         carry_wr_data,
    input  logic         flush
);

    logic         e_valid;
    instruction_t e_instr;
    logic         e_tag;
    logic         last_grant;

    logic         o_free;
    logic         e_move;
    logic         e_free;
    logic         grant;
    logic         accept_ok;
    logic         accept;
    logic         carry_op;
    long_t        alu_result;
    logic         alu_carry;

    bitwise u_bitwise (
        .i_instr (e_instr),
        .i_carry (carry_flag),
        .result  (alu_result),
        .o_carry (alu_carry)
    );

    always_comb begin
        o_free = !res_valid | res_ready;
        e_move = e_valid & o_free;
        e_free = !e_valid | e_move;
        // prefer the port that did not win last time, else whichever is valid
        if (last_grant ? req0_valid : req1_valid)
            grant = ~last_grant;
        else
            grant = last_grant;
        accept_ok  = !rst & !flush & e_free & (req0_valid | req1_valid);
        req0_ready = accept_ok & !grant;
        req1_ready = accept_ok & grant;
        accept     = req0_ready | req1_ready;
        carry_op   = e_instr.flags[USE_CARRY_BIT] &
                     (e_instr.opcode inside {ROLR, ROLL, SHIFTR, SHIFTL});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid    <= 1'b0;
            e_instr    <= '0;
            e_tag      <= 1'b0;
            last_grant <= 1'b1;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_carry  <= 1'b0;
            res_tag    <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            if (flush) begin
                e_valid   <= 1'b0;
                res_valid <= 1'b0;
            end else begin
                if (e_move) begin
                    res_valid <= 1'b1;
                    res_data  <= alu_result;
                    res_carry <= alu_carry;
                    res_tag   <= e_tag;
                end else if (res_ready) begin
                    res_valid <= 1'b0;
                end
                if (accept) begin
                    e_valid    <= 1'b1;
                    e_instr    <= grant ? req1_instr : req0_instr;
                    e_tag      <= grant;
                    last_grant <= grant;
                end else if (e_move) begin
                    e_valid <= 1'b0;
                end
            end
            // the ALU carry update takes priority over an external write
            if (!flush && e_move && carry_op)
                carry_flag <= alu_carry;
            else if (carry_wr_en)
                carry_flag <= carry_wr_data;
        end
    end

endmodule

// File: tb/tb_bitwise_issue_arbiter.sv
// tb/tb_bitwise_issue_arbiter.sv - vector table and scoreboard bench for bitwise_issue_arbiter
module tb_bitwise_issue_arbiter;
    import types::*;

    typedef struct {
        logic       port;
        opcode_t    op;
        width_t     w;
        logic [3:0] flags;
        long_t      a0;
        long_t      a1;
        long_t      exp_d;
        logic       exp_c;
    } vec_t;

    typedef struct {
        long_t d;
        logic  c;
        logic  tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    instruction_t req0_instr, req1_instr;
    logic         req0_ready, req1_ready;
    logic         res_valid, res_ready;
    long_t        res_data;
    logic         res_carry, res_tag, carry_flag;
    logic         carry_wr_en, carry_wr_data, flush;

    vec_t  vec [19];
    exp_t  sb [$];
    int    res_cyc [$];
    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;

    bitwise_issue_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_instr    (req0_instr),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_instr    (req1_instr),
        .req1_ready    (req1_ready),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_carry     (res_carry),
        .res_tag       (res_tag),
        .carry_flag    (carry_flag),
        .carry_wr_en   (carry_wr_en),
        .carry_wr_data (carry_wr_data),
        .flush         (flush)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic instruction_t mk(input int i);
        instruction_t t;
        t.opcode = vec[i].op;
        t.width  = vec[i].w;
        t.flags  = vec[i].flags;
        t.arg0   = vec[i].a0;
        t.arg1   = vec[i].a1;
        return t;
    endfunction

    always @(negedge clk) begin
        if (!rst && !flush && res_valid && res_ready) begin
            exp_t e;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got data=%h tag=%0d with nothing expected", res_data, res_tag);
            end else begin
                e = sb.pop_front();
                res_cyc.push_back(cyc);
                if (res_data !== e.d || res_carry !== e.c || res_tag !== e.tag) begin
                    n_err++;
                    $display("FAIL result: got data=%h carry=%0d tag=%0d expected data=%h carry=%0d tag=%0d",
                             res_data, res_carry, res_tag, e.d, e.c, e.tag);
                end
            end
        end
    end

    task automatic run_table(input int lo, input int hi, input int stall);
        int    q0 [$];
        int    q1 [$];
        int    acc;
        int    first_acc;
        int    dummy;
        long_t prev;
        logic  prev_v;
        for (int i = lo; i <= hi; i++) begin
            if (vec[i].port) q1.push_back(i);
            else             q0.push_back(i);
            sb.push_back('{vec[i].exp_d, vec[i].exp_c, vec[i].port});
        end
        res_cyc.delete();
        first_acc = -1;
        acc = 0;
        prev = '0;
        prev_v = 1'b0;
        for (int k = 0; k < 200 && (q0.size() != 0 || q1.size() != 0); k++) begin
            @(posedge clk); #1;
            res_ready  = (k >= stall);
            req0_valid = (q0.size() != 0);
            req1_valid = (q1.size() != 0);
            if (req0_valid) req0_instr = mk(q0[0]);
            if (req1_valid) req1_instr = mk(q1[0]);
            @(negedge clk);
            if (k < stall && res_valid) begin
                if (prev_v) chk("hold_data", res_data, prev);
                prev = res_data;
                prev_v = 1'b1;
            end
            if (req0_ready && q0.size() != 0) begin
                dummy = q0.pop_front();
                acc++;
                if (first_acc < 0) first_acc = cyc;
            end
            if (req1_ready && q1.size() != 0) begin
                dummy = q1.pop_front();
                acc++;
                if (first_acc < 0) first_acc = cyc;
            end
            if (stall > 0 && k == stall - 1) chk("stall_accepts", acc, 2);
        end
        chk("issue_timeout", q0.size() + q1.size(), 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        for (int k = 0; k < 50 && sb.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        chk("drain", sb.size(), 0);
        if (stall == 0 && res_cyc.size() != 0) begin
            chk("latency", res_cyc[0] - first_acc, 2);
            chk("throughput", res_cyc[res_cyc.size() - 1] - res_cyc[0], hi - lo);
        end
    endtask

    task automatic collide(input int i, input logic exp_flag);
        sb.push_back('{vec[i].exp_d, vec[i].exp_c, vec[i].port});
        @(posedge clk); #1;
        req0_valid = 1'b1;
        req0_instr = mk(i);
        @(posedge clk); #1;
        req0_valid    = 1'b0;
        carry_wr_en   = 1'b1;
        carry_wr_data = 1'b1;
        @(posedge clk); #1;
        carry_wr_en   = 1'b0;
        @(negedge clk);
        chk("collide_flag", carry_flag, exp_flag);
        #1;
        chk("collide_drain", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec[0]  = '{1'b0, XOR,    W8,  4'h0, 64'hF0, 64'hFF, 64'h0F, 1'b0};
        vec[1]  = '{1'b1, XOR,    W8,  4'h0, 64'h01, 64'h03, 64'h02, 1'b0};
        vec[2]  = '{1'b0, AND,    W64, 4'h0, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0000_0F0F_0000, 1'b0};
        vec[3]  = '{1'b1, OR,     W16, 4'h0, 64'h1234_0000_0000_00F0, 64'h000F, 64'h00FF, 1'b0};
        vec[4]  = '{1'b0, NOT,    W32, 4'h0, 64'h1234_5678, 64'h0, 64'hEDCB_A987, 1'b0};
        vec[5]  = '{1'b1, ROLL,   W8,  4'h0, 64'h81, 64'h1, 64'h03, 1'b0};
        vec[6]  = '{1'b0, ROLR,   W16, 4'h0, 64'h0001, 64'h4, 64'h1000, 1'b0};
        vec[7]  = '{1'b1, SHIFTR, W32, 4'h0, 64'hF000_0000, 64'h8, 64'h00F0_0000, 1'b0};
        vec[8]  = '{1'b0, ADD,    W64, 4'h0, 64'h5, 64'h6, 64'h0, 1'b0};
        vec[9]  = '{1'b1, XOR,    W64, 4'h0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vec[10] = '{1'b0, SHIFTL, W8,  4'h1, 64'h81, 64'h1, 64'h02, 1'b1};
        vec[11] = '{1'b0, SHIFTL, W8,  4'h1, 64'h01, 64'h1, 64'h02, 1'b0};
        vec[12] = '{1'b0, NOT,    W8,  4'h0, 64'h0F, 64'h0, 64'hF0, 1'b0};
        vec[13] = '{1'b1, OR,     W8,  4'h0, 64'h50, 64'h05, 64'h55, 1'b0};
        vec[14] = '{1'b0, AND,    W8,  4'h0, 64'h3C, 64'hF0, 64'h30, 1'b0};
        vec[15] = '{1'b1, ROLL,   W64, 4'h1, 64'h8000_0000_0000_0001, 64'h4, 64'h18, 1'b0};
        vec[16] = '{1'b0, SHIFTL, W8,  4'h1, 64'h01, 64'h1, 64'h02, 1'b0};
        vec[17] = '{1'b0, SHIFTL, W8,  4'h1, 64'h80, 64'h1, 64'h00, 1'b1};
        vec[18] = '{1'b1, XOR,    W8,  4'h0, 64'h0F, 64'hF0, 64'hFF, 1'b0};

        rst = 1'b1;
        res_ready = 1'b1;
        flush = 1'b0;
        carry_wr_en = 1'b0;
        carry_wr_data = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_instr = mk(0);
        req1_instr = mk(1);
        repeat (2) begin
            @(negedge clk);
            chk("reset_flags", {req0_ready, req1_ready, res_valid, carry_flag, res_carry, res_tag}, 0);
            chk("reset_data", res_data, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        run_table(0, 9, 0);

        chk("carry_pre", carry_flag, 0);
        run_table(10, 10, 0);
        chk("carry_after", carry_flag, 1);

        collide(11, 1'b0);
        collide(12, 1'b1);

        run_table(13, 15, 4);

        sb.delete();
        @(posedge clk); #1;
        res_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_instr = mk(16);
        @(posedge clk); #1;
        req0_instr = mk(17);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_instr = mk(18);
        flush      = 1'b1;
        res_ready  = 1'b1;
        @(negedge clk);
        chk("flush_ready", {req0_ready, req1_ready}, 0);
        chk("flush_pre_valid", res_valid, 1);
        @(posedge clk); #1;
        flush      = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("flush_res_valid", res_valid, 0);
        chk("flush_carry", carry_flag, 0);
        repeat (4) @(negedge clk);
        chk("flush_idle", res_valid, 0);

        @(posedge clk); #1;
        carry_wr_en   = 1'b1;
        carry_wr_data = 1'b1;
        @(posedge clk); #1;
        carry_wr_en   = 1'b0;
        @(negedge clk);
        chk("carry_wr", carry_flag, 1);

        run_table(18, 18, 0);
        chk("carry_kept", carry_flag, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
